// File: rtl/pcx2mb_sm.sv
// -----------------------------------------------------------------------------
// pcx2mb_sm
//   Bridges PCX request packets onto a 32-bit FSL master port. Each accepted
//   packet ({1'b0, hdr[2:0], data[123:0]}, 128 bits) is parked in a one-entry
//   holding register. It is then moved into a shift register and emitted as
//   four FSL words, MSB word first. An atomic packet waits in AT_WAIT until
//   its partner arrives, so that the pair streams out as 8 contiguous words.
//
// Ports
//   rclk               clock, all state on rising edge
//   reset_l            synchronous active-low reset
//   pcx_req_vld        upstream packet valid
//   pcx_req_atom       packet is the first of an atomic pair
//   pcx_req_hdr[2:0]   header bits carried with the packet
//   pcx_req_data[123:0] packet payload
//   pcx_req_rdy        holding register empty (registered)
//   fsl_pcx_m_full     FSL master FIFO full
//   pcx_fsl_m_write    FSL write strobe
//   pcx_fsl_m_data     FSL write data
//   pcx_fsl_m_control  marks the first word of a packet
//   pcx_spc_grant_px   one-cycle pulse per packet fully written
// -----------------------------------------------------------------------------
module pcx2mb_sm (
  input  logic         rclk,
  input  logic         reset_l,
  input  logic         pcx_req_vld,
  input  logic         pcx_req_atom,
  input  logic [2:0]   pcx_req_hdr,
  input  logic [123:0] pcx_req_data,
  output logic         pcx_req_rdy,
  input  logic         fsl_pcx_m_full,
  output logic         pcx_fsl_m_write,
  output logic [31:0]  pcx_fsl_m_data,
  output logic         pcx_fsl_m_control,
  output logic         pcx_spc_grant_px
);

  localparam int DATA_W = 124;
  localparam int WORD_W = 32;
  localparam int PKT_W  = 128;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    SHIFT   = 3'b010,
    AT_WAIT = 3'b100
  } state_t;

  state_t              state;
  logic [1:0]          word_cnt;
  logic                at_pend;
  logic                grant;

  logic                hold_vld;
  logic                hold_atom_p0;
  logic [2:0]          hold_hdr_p0;
  logic [DATA_W-1:0]   hold_data_p0;

  logic [PKT_W-1:0]    shift_p1;

  logic                accept;
  logic                fsl_write;
  logic                last_word;
  logic                load;
  logic                shift_adv;

  // The strobe is also gated by reset_l so that a packet interrupted by reset
  // stops on the very cycle reset is asserted.
  assign accept    = pcx_req_vld && !hold_vld;
  assign fsl_write = (state == SHIFT) && !fsl_pcx_m_full && reset_l;
  assign last_word = fsl_write && (word_cnt == 2'd0);
  assign shift_adv = fsl_write && (word_cnt != 2'd0);

  always_comb begin
    load = 1'b0;
    if (state == IDLE && hold_vld)
      load = 1'b1;
    else if (last_word && (at_pend || hold_vld))
      load = 1'b1;
  end

  assign pcx_req_rdy       = !hold_vld;
  assign pcx_fsl_m_write   = fsl_write;
  assign pcx_fsl_m_data    = (state == SHIFT) ? shift_p1[PKT_W-1 -: WORD_W] : '0;
  assign pcx_fsl_m_control = (state == SHIFT) && (word_cnt == 2'd3);
  assign pcx_spc_grant_px  = grant;

  // Stage p0: holding register capture; stage p1: shift register load/advance
  always_ff @(posedge rclk) begin
    if (accept) begin
      hold_atom_p0 <= pcx_req_atom;
      hold_hdr_p0  <= pcx_req_hdr;
      hold_data_p0 <= pcx_req_data;
    end
    if (load)
      shift_p1 <= {1'b0, hold_hdr_p0, hold_data_p0};
    else if (shift_adv)
      shift_p1 <= {shift_p1[PKT_W-WORD_W-1:0], {WORD_W{1'b0}}};
  end

  always_ff @(posedge rclk) begin
    if (!reset_l) begin
      state    <= IDLE;
      word_cnt <= 2'd0;
      hold_vld <= 1'b0;
      at_pend  <= 1'b0;
      grant    <= 1'b0;
    end else begin
      grant <= last_word;

      // Load and accept are mutually exclusive: accept needs an empty hold,
      // load needs a full one.
      if (load)
        hold_vld <= 1'b0;
      else if (accept)
        hold_vld <= 1'b1;

      if (load)
        word_cnt <= 2'd3;
      else if (shift_adv)
        word_cnt <= word_cnt - 2'd1;

      case (state)
        IDLE: begin
          if (hold_vld) begin
            if (hold_atom_p0) begin
              state   <= AT_WAIT;
              at_pend <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        AT_WAIT: begin
          // Partner packet stays in hold; it is loaded when the first ends.
          if (hold_vld)
            state <= SHIFT;
        end
        SHIFT: begin
          if (last_word) begin
            if (at_pend) begin
              at_pend <= 1'b0;
              state   <= SHIFT;
            end else if (hold_vld && hold_atom_p0) begin
              at_pend <= 1'b1;
              state   <= AT_WAIT;
            end else if (hold_vld) begin
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          word_cnt <= 2'd0;
          at_pend  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcx2mb_sm.sv
module tb_pcx2mb_sm;

  logic         rclk;
  logic         reset_l;
  logic         pcx_req_vld;
  logic         pcx_req_atom;
  logic [2:0]   pcx_req_hdr;
  logic [123:0] pcx_req_data;
  logic         pcx_req_rdy;
  logic         fsl_pcx_m_full;
  logic         pcx_fsl_m_write;
  logic [31:0]  pcx_fsl_m_data;
  logic         pcx_fsl_m_control;
  logic         pcx_spc_grant_px;

  pcx2mb_sm dut (
    .rclk              (rclk),
    .reset_l           (reset_l),
    .pcx_req_vld       (pcx_req_vld),
    .pcx_req_atom      (pcx_req_atom),
    .pcx_req_hdr       (pcx_req_hdr),
    .pcx_req_data      (pcx_req_data),
    .pcx_req_rdy       (pcx_req_rdy),
    .fsl_pcx_m_full    (fsl_pcx_m_full),
    .pcx_fsl_m_write   (pcx_fsl_m_write),
    .pcx_fsl_m_data    (pcx_fsl_m_data),
    .pcx_fsl_m_control (pcx_fsl_m_control),
    .pcx_spc_grant_px  (pcx_spc_grant_px)
  );

  typedef struct {
    logic [31:0] d;
    logic        ctl;
    logic        last;
  } exp_t;

  exp_t        sb_q[$];
  int          wr_cyc_q[$];
  logic [31:0] wr_d_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          grant_cnt = 0;
  bit          grant_due = 0;
  bit          mon_en = 0;
  int          full_mode = 0;

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  always @(posedge rclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a packet is the 128-bit value {0, hdr, data} cut into
  // four 32-bit words, MSB first; the first carries control, the last
  // earns a grant. Packets leave in the order they were accepted.
  task automatic push_pkt(input logic [2:0] hdr, input logic [123:0] data);
    logic [127:0] pkt;
    exp_t e;
    pkt = {1'b0, hdr, data};
    for (int i = 0; i < 4; i++) begin
      e.d    = pkt[127 - 32*i -: 32];
      e.ctl  = (i == 0);
      e.last = (i == 3);
      sb_q.push_back(e);
    end
  endtask

  // Full driver
  initial begin
    fsl_pcx_m_full = 1'b0;
    forever begin
      @(posedge rclk);
      #1;
      case (full_mode)
        1: fsl_pcx_m_full = ~fsl_pcx_m_full;
        2: fsl_pcx_m_full = ($urandom_range(0, 3) == 0);
        default: fsl_pcx_m_full = 1'b0;
      endcase
    end
  end

  // Monitor: samples on the falling edge, describing the coming rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge rclk);
      if (!mon_en) continue;
      if (!reset_l) begin
        grant_due = 0;
        chk("wr_in_reset", {63'd0, pcx_fsl_m_write}, 64'd0);
        continue;
      end
      chk("grant", {63'd0, pcx_spc_grant_px}, {63'd0, grant_due});
      if (pcx_spc_grant_px) grant_cnt++;
      grant_due = 0;
      chk("no_wr_when_full", {63'd0, pcx_fsl_m_write & fsl_pcx_m_full}, 64'd0);
      if (pcx_fsl_m_write) begin
        wr_count++;
        wr_cyc_q.push_back(cyc + 1);
        wr_d_q.push_back(pcx_fsl_m_data);
        if (sb_q.size() == 0) begin
          chk("unexpected_wr", {63'd0, pcx_fsl_m_write}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("wr_data", {32'd0, pcx_fsl_m_data}, {32'd0, e.d});
          chk("wr_ctl", {63'd0, pcx_fsl_m_control}, {63'd0, e.ctl});
          if (e.last) grant_due = 1;
        end
      end else if (sb_q.size() == 0) begin
        chk("idle_data", {32'd0, pcx_fsl_m_data}, 64'd0);
        chk("idle_ctl", {63'd0, pcx_fsl_m_control}, 64'd0);
      end
    end
  end

  task automatic send_pkt(input logic [2:0] hdr, input logic [123:0] data,
                          input logic atom, output int acc_cyc);
    bit r;
    bit done;
    int n;
    done = 0;
    n = 0;
    acc_cyc = -1;
    pcx_req_vld  = 1'b1;
    pcx_req_hdr  = hdr;
    pcx_req_data = data;
    pcx_req_atom = atom;
    while (!done) begin
      @(negedge rclk);
      r = pcx_req_rdy;
      @(posedge rclk);
      #1;
      if (r) begin
        done = 1;
      end else if (++n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept in 200 cycles, required accept");
        break;
      end
    end
    if (done) begin
      push_pkt(hdr, data);
      acc_cyc = cyc;
    end
    pcx_req_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 1000) begin
      @(posedge rclk);
      #1;
      n++;
    end
    chk("drain_left", sb_q.size(), 64'd0);
    repeat (2) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic clr_log();
    wr_cyc_q.delete();
    wr_d_q.delete();
  endtask

  task automatic rnd_pkt(output logic [2:0] hdr, output logic [123:0] data);
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    data = t[123:0];
    hdr = 3'($urandom_range(0, 7));
  endtask

  initial begin
    logic [2:0]   h;
    logic [123:0] d;
    int           acc;
    int           gbase;
    int           wbase;
    int           n;
    bit           pair_open;
    logic         atom;

    reset_l      = 1'b0;
    pcx_req_vld  = 1'b0;
    pcx_req_atom = 1'b0;
    pcx_req_hdr  = '0;
    pcx_req_data = '0;

    // Reset state
    @(posedge rclk);
    #1;
    mon_en = 1;
    @(posedge rclk);
    @(negedge rclk);
    chk("rst_rdy", {63'd0, pcx_req_rdy}, 64'd1);
    chk("rst_write", {63'd0, pcx_fsl_m_write}, 64'd0);
    chk("rst_ctl", {63'd0, pcx_fsl_m_control}, 64'd0);
    chk("rst_data", {32'd0, pcx_fsl_m_data}, 64'd0);
    chk("rst_grant", {63'd0, pcx_spc_grant_px}, 64'd0);
    @(posedge rclk);
    #1;
    reset_l = 1'b1;
    repeat (2) begin
      @(posedge rclk);
      #1;
    end

    // Single packet, latency, first word value
    clr_log();
    gbase = grant_cnt;
    send_pkt(3'b101, 124'h0A5_5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A, 1'b0, acc);
    @(negedge rclk);
    chk("rdy_busy", {63'd0, pcx_req_rdy}, 64'd0);
    drain();
    chk("single_nwr", wr_cyc_q.size(), 64'd4);
    if (wr_cyc_q.size() == 4) begin
      chk("single_latency", wr_cyc_q[0] - acc, 64'd2);
      chk("single_w0", {32'd0, wr_d_q[0]}, 64'h50A55A5A);
      chk("single_contig", wr_cyc_q[3] - wr_cyc_q[0], 64'd3);
    end
    chk("single_grants", grant_cnt - gbase, 64'd1);

    // Two non-atomic packets back to back
    clr_log();
    gbase = grant_cnt;
    rnd_pkt(h, d);
    send_pkt(h, d, 1'b0, acc);
    rnd_pkt(h, d);
    send_pkt(h, d, 1'b0, acc);
    drain();
    chk("b2b_nwr", wr_cyc_q.size(), 64'd8);
    if (wr_cyc_q.size() == 8)
      chk("b2b_contig", wr_cyc_q[7] - wr_cyc_q[0], 64'd7);
    chk("b2b_grants", grant_cnt - gbase, 64'd2);

    // Atomic pair, partner 10 cycles late
    clr_log();
    gbase = grant_cnt;
    rnd_pkt(h, d);
    send_pkt(h, d, 1'b1, acc);
    repeat (10) begin
      @(posedge rclk);
      #1;
    end
    chk("atwait_nwr", wr_cyc_q.size(), 64'd0);
    rnd_pkt(h, d);
    send_pkt(h, d, 1'b0, acc);
    drain();
    chk("atom_nwr", wr_cyc_q.size(), 64'd8);
    if (wr_cyc_q.size() == 8)
      chk("atom_contig", wr_cyc_q[7] - wr_cyc_q[0], 64'd7);
    chk("atom_grants", grant_cnt - gbase, 64'd2);

    // Full toggling every cycle
    clr_log();
    full_mode = 1;
    rnd_pkt(h, d);
    send_pkt(h, d, 1'b0, acc);
    drain();
    chk("toggle_nwr", wr_cyc_q.size(), 64'd4);
    full_mode = 0;
    repeat (2) begin
      @(posedge rclk);
      #1;
    end

    // Reset after w1
    clr_log();
    gbase = grant_cnt;
    rnd_pkt(h, d);
    send_pkt(h, d, 1'b0, acc);
    wbase = wr_count;
    n = 0;
    while (wr_count - wbase < 2 && n < 100) begin
      @(posedge rclk);
      #1;
      n++;
    end
    chk("rstmid_reach_w1", wr_count - wbase, 64'd2);
    reset_l = 1'b0;
    sb_q.delete();
    @(posedge rclk);
    #1;
    reset_l = 1'b1;
    @(negedge rclk);
    chk("rstmid_rdy", {63'd0, pcx_req_rdy}, 64'd1);
    chk("rstmid_ctl", {63'd0, pcx_fsl_m_control}, 64'd0);
    repeat (10) begin
      @(posedge rclk);
      #1;
    end
    chk("rstmid_nwr", wr_cyc_q.size(), 64'd2);
    chk("rstmid_grants", grant_cnt - gbase, 64'd0);

    // Randomized traffic
    full_mode = 2;
    pair_open = 0;
    gbase = grant_cnt;
    for (int i = 0; i < 60 || pair_open; i++) begin
      if (pair_open) begin
        atom = 1'b0;
        pair_open = 0;
      end else begin
        atom = ($urandom_range(0, 3) == 0);
        pair_open = atom;
      end
      rnd_pkt(h, d);
      send_pkt(h, d, atom, acc);
      repeat ($urandom_range(0, 3)) begin
        @(posedge rclk);
        #1;
      end
      if (i > 200) break;
    end
    drain();
    full_mode = 0;
    repeat (3) begin
      @(posedge rclk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcx2mb_sm.md
PCX2MB_SM -- requirements
Module: pcx2mb_sm

Interface
REQ-001 Port rclk  input  1  Rising-edge clock for all state.
REQ-002 Port reset_l  input  1  Reset; synchronous and active-low, sampled on rising edge of rclk.
REQ-003 Port pcx_req_vld  input  1  Upstream PCX packet valid.
REQ-004 Port pcx_req_atom  input  1  Packet is first of an atomic pair.
REQ-005 Port pcx_req_hdr  input  3  Header bits carried with packet.
REQ-006 Port pcx_req_data  input  124  PCX packet payload.
REQ-007 Port pcx_req_rdy  output  1  Holding buffer empty; packet accepted on vld && rdy.
REQ-008 Port fsl_pcx_m_full  input  1  FSL master FIFO full.
REQ-009 Port pcx_fsl_m_write  output  1  FSL write strobe.
REQ-010 Port pcx_fsl_m_data  output  32  FSL write data.
REQ-011 Port pcx_fsl_m_control  output  1  FSL control bit; marks first word of packet.
REQ-012 Port pcx_spc_grant_px  output  1  One-cycle pulse per packet fully written to FSL.

Function
REQ-013 Each packet SHALL occupy 128 bits = {1'b0, hdr[2:0], data[123:0]}, sent as exactly 4 FSL words, MSB word first.
REQ-014 Word order SHALL be: w0 = {1'b0, hdr, data[123:96]}, w1 = data[95:64], w2 = data[63:32], w3 = data[31:0].
REQ-015 Block SHALL hold one holding register (hold_vld, hdr, data, atom) and one 128-bit shift register with a 2-bit word counter.
REQ-016 pcx_req_rdy SHALL equal !hold_vld, driven from a register only, with no combinational path from any input.
REQ-017 vld && rdy SHALL set hold_vld and capture hdr/data/atom on that edge.
REQ-018 The state machine SHALL be one-hot with three states: IDLE = 3'b001, SHIFT = 3'b010, AT_WAIT = 3'b100.
REQ-019 The "load" action SHALL: copy hold into the shift register, set count = 3, and clear hold_vld; hold is never loaded and accepted in the same cycle.
REQ-020 IDLE: if hold_vld, perform load; if hold atom = 1, go to AT_WAIT and set at_pend = 1; otherwise go to SHIFT. If !hold_vld, stay in IDLE.
REQ-021 AT_WAIT: no FSL writes; when hold_vld = 1 (second packet of the pair), go to SHIFT without loading. Second packet stays in hold.
REQ-022 SHIFT: pcx_fsl_m_write = !fsl_pcx_m_full, combinational; no write and no count change while full.
REQ-023 pcx_fsl_m_data SHALL equal shift[127:96]; pcx_fsl_m_control SHALL equal (count == 3) in SHIFT; both outputs SHALL be 0 outside SHIFT.
REQ-024 Each write with count != 0: shift <<= 32 and count decrements by 1.
REQ-025 Write with count == 0 (end of packet): grant SHALL pulse on the next cycle, then:
 - if at_pend = 1: load, clear at_pend, go to SHIFT (hold's atom bit is ignored);
 - else if hold_vld and hold atom = 1: load, set at_pend, go to AT_WAIT;
 - else if hold_vld: load, go to SHIFT;
 - else: go to IDLE.
REQ-026 Back-to-back packets SHALL stream with no idle cycle between w3 and the next w0 when FSL is not full.
REQ-027 An atomic pair SHALL appear on FSL as 8 contiguous words; no other packet is interleaved between them.
REQ-028 Latency: a packet accepted into an empty block in IDLE SHALL have w0 written 2 cycles after the accept edge, given !full.
REQ-029 An illegal or zero state encoding SHALL return the block to IDLE with count = 0 and at_pend = 0.

Reset
REQ-030 While reset_l = 0, on each edge:
 - state = IDLE, count = 0, hold_vld = 0, at_pend = 0, grant = 0;
 - hence pcx_req_rdy = 1 and pcx_fsl_m_write = 0, pcx_fsl_m_control = 0, pcx_fsl_m_data = 0.
REQ-031 Reset mid-packet SHALL discard the partial packet and the holding register, with no grant issued.

Verification
REQ-032 Single packet (hdr = 3'b101, data = 124'h0A5_5A5A5A5A_..., atom = 0) with full = 0 -> four writes; w0 control = 1 and w0 = {1'b0, 3'b101, data[123:96]}; grant pulses one cycle after w3.
REQ-033 Two non-atomic packets back to back -> 8 consecutive write cycles, control on cycles 1 and 5, two grants.
REQ-034 Atomic pair where the second packet arrives 10 cycles late -> no writes while in AT_WAIT, then 8 contiguous writes and two grants.
REQ-035 fsl_pcx_m_full toggled 1/0 each cycle during a packet -> writes only on !full cycles, data order preserved, exactly 4 writes.
REQ-036 reset_l = 0 after w1 of a packet -> no further writes, no grant, pcx_req_rdy = 1 on the cycle after reset.
